reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Next-generation integer register file for the pipelined core: N read ports, 1 write port, x0 hardwired zero.
//  Adds a per-register pending scoreboard (RAW hazard detection for issue logic) and a sequential bulk-clear engine.
//  Sits between decode/issue (read + reserve) and writeback (write + release).
// PARAMETERS
//  DataWidth    64               register width in bits
//  NumRegs      32               number of architectural registers (>=2)
//  IndexWidth   $clog2(NumRegs)  address width
//  NumReadPorts 2                independent read ports (>=1)
// PORTS
//  clk         in   1                        clock, rising edge
//  rst         in   1                        asynchronous reset, active-low
//  writeEn     in   1                        writeback strobe
//  writeAddr   in   IndexWidth               writeback register index
//  writeData   in   DataWidth                writeback value
//  readAddr    in   NumReadPorts*IndexWidth  read indices, port p at [p*IndexWidth +: IndexWidth]
//  readData    out  NumReadPorts*DataWidth   read values, same packing
//  readBusy    out  NumReadPorts             1 = addressed register has a pending write
//  issueEn     in   1                        reserve destination register
//  issueAddr   in   IndexWidth               register to mark pending
//  clearReq    in   1                        start bulk clear (pulse or level)
//  clearBusy   out  1                        clear engine active
// BEHAVIOUR
//  Reset (rst=0, async): all registers 0, all pending bits 0, FSM IDLE, clearBusy=0; readData reflects zeros.
//  Reads: combinational, zero latency. Index 0 always returns 0 and readBusy=0. Index >= NumRegs returns 0, busy 0.
//  Write: on clk rise with writeEn=1 and writeAddr!=0, reg[writeAddr]<=writeData; writes to x0 dropped.
//  Scoreboard: issueEn sets pending[issueAddr] at next edge (ignored for x0); writeEn clears pending[writeAddr].
//   Same-cycle issue and write to the same index: pending stays SET (new producer wins), data still written.
//   readBusy[p] = pending[readAddr[p]] as registered (not including same-cycle issue).
//  FSM states: IDLE, CLEAR.
//   IDLE -> CLEAR when clearReq=1; clear pointer loads 1.
//   CLEAR: each cycle reg[ptr]<=0, pending[ptr]<=0, ptr++; after ptr==NumRegs-1 is cleared -> IDLE.
//   Clear takes exactly NumRegs-1 cycles; clearBusy=1 throughout CLEAR, 0 on the IDLE cycle after.
//   During CLEAR writeEn and issueEn ignored (sources must stall on clearBusy); reads stay legal and return
//   current (partially cleared) contents. clearReq while in CLEAR ignored (no restart).
//  Reset mid-clear: immediate return to IDLE with full reset state.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-through; a read of writeAddr in the write cycle returns writeData and
//   readBusy=0 for that port (writeback releasing the hazard the same cycle). x0 and CLEAR cycles never bypass.
//  Undefined: reads return stored value; new data visible the cycle after the edge; busy clears after the edge.
// STRUCTURE
//  Package reg_file_pkg: typedef enum logic {IDLE, CLEAR} rf_state_t; localparam ZERO_REG = 0.
//  Sub-module reg_file_scoreboard: pending bit vector, set/clear/priority rules, clear-pointer clearing input.
//  Top holds storage array, read muxes, bypass, FSM.
// TESTING
//  1 Reset then read all ports at 0..31 -> readData=0, readBusy=0, clearBusy=0.
//  2 Write 64'hFFFF_FFFF_FFFF_FFFF to x1..x31, then read port0=i, port1=i-1 -> all FFFF.. except x0=0.
//  3 Write 64'hDEAD_BEEF to x0 -> x0 still reads 0; issueEn on x0 -> readBusy stays 0.
//  4 issue x5; next cycle readBusy=1; write x5=64'h1234 -> with BYPASS busy=0 & data 1234 in write cycle,
//    without BYPASS busy=0 & data 1234 next cycle; issue+write x7 same cycle -> busy stays 1.
//  5 Fill x1..x31 with 64'hA5, pend x9, clearReq 1 cycle -> clearBusy high 31 cycles; write x3 during clear
//    dropped; after: all regs 0, readBusy all 0.
//  6 Assert rst low at clear cycle 10 -> immediate zeros, clearBusy=0, FSM IDLE; next clearReq restarts from x1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the integer register file and its scoreboard.
package reg_file_pkg;

    typedef enum logic {IDLE, CLEAR} rf_state_t;

    localparam int ZERO_REG = 0;

    // True when idx addresses an implemented register.
    function automatic logic idx_ok(input int unsigned idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, released on writeback,
// wiped one entry per cycle by the bulk-clear engine.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NumRegs    = 32,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [IndexWidth-1:0] set_addr,
    input  logic                  rel_en,
    input  logic [IndexWidth-1:0] rel_addr,
    input  logic                  wipe_en,
    input  logic [IndexWidth-1:0] wipe_addr,
    output logic [NumRegs-1:0]    pending
);

    logic [NumRegs-1:0] pending_nxt;

    // Set is applied last so a new producer outranks a same-cycle release.
    always_comb begin
        pending_nxt = pending;
        if (wipe_en) pending_nxt[wipe_addr] = 1'b0;
        if (rel_en)  pending_nxt[rel_addr]  = 1'b0;
        if (set_en)  pending_nxt[set_addr]  = 1'b1;
        pending_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= '0;
        else      pending <= pending_nxt;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with RAW scoreboard and sequential bulk-clear engine.
// Optional write-through bypass: define REGFILE_BYPASS_EN.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DataWidth    = 64,
    parameter int NumRegs      = 32,
    parameter int IndexWidth   = $clog2(NumRegs),
    parameter int NumReadPorts = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               writeEn,
    input  logic [IndexWidth-1:0]              writeAddr,
    input  logic [DataWidth-1:0]               writeData,
    input  logic [NumReadPorts*IndexWidth-1:0] readAddr,
    output logic [NumReadPorts*DataWidth-1:0]  readData,
    output logic [NumReadPorts-1:0]            readBusy,
    input  logic                               issueEn,
    input  logic [IndexWidth-1:0]              issueAddr,
    input  logic                               clearReq,
    output logic                               clearBusy
);

    localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);
    localparam logic [IndexWidth-1:0] ZeroIdx = IndexWidth'(ZERO_REG);

    rf_state_t             state, state_nxt;
    logic [IndexWidth-1:0] ptr;
    logic [DataWidth-1:0]  regs [NumRegs];
    logic [NumRegs-1:0]    pending;
    logic                  idle, wr_ok, iss_ok;

    assign idle      = (state == IDLE);
    assign clearBusy = ~idle;
    // Writeback and issue are only honoured outside the clear sweep.
    assign wr_ok  = idle && writeEn && (writeAddr != ZeroIdx)
                    && idx_ok(32'(writeAddr), NumRegs);
    assign iss_ok = idle && issueEn && (issueAddr != ZeroIdx)
                    && idx_ok(32'(issueAddr), NumRegs);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (idle && clearReq) ptr <= IndexWidth'(1);
            else if (!idle)       ptr <= ptr + IndexWidth'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clearReq) state_nxt = CLEAR;
            CLEAR:   if (ptr == LastIdx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // x0 is never written: writes exclude it and the sweep starts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
        end else if (!idle) begin
            regs[ptr] <= '0;
        end else if (wr_ok) begin
            regs[writeAddr] <= writeData;
        end
    end

    reg_file_scoreboard #(.NumRegs(NumRegs), .IndexWidth(IndexWidth)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_ok),
        .set_addr (issueAddr),
        .rel_en   (wr_ok),
        .rel_addr (writeAddr),
        .wipe_en  (!idle),
        .wipe_addr(ptr),
        .pending  (pending)
    );

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
        logic [IndexWidth-1:0] ra;
        logic [DataWidth-1:0]  rd;
        logic                  rb;
        logic                  hit;

        assign ra = readAddr[p*IndexWidth +: IndexWidth];
`ifdef REGFILE_BYPASS_EN
        assign hit = wr_ok && (ra == writeAddr);
`else
        assign hit = 1'b0;
`endif

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (hit) begin
                rd = writeData;
            end else if (ra != ZeroIdx && idx_ok(32'(ra), NumRegs)) begin
                rd = regs[ra];
                rb = pending[ra];
            end
        end

        assign readData[p*DataWidth +: DataWidth] = rd;
        assign readBusy[p]                        = rb;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: vector table plus hand sequences for clear and reset.
module tb_reg_file_sb;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        writeEn = 1'b0;
    logic [4:0]  writeAddr = '0;
    logic [63:0] writeData = '0;
    logic [4:0]  ra0 = '0, ra1 = '0;
    logic [9:0]  readAddr;
    logic [127:0] readData;
    logic [1:0]  readBusy;
    logic        issueEn = 1'b0;
    logic [4:0]  issueAddr = '0;
    logic        clearReq = 1'b0;
    logic        clearBusy;

    int checks = 0;
    int errors = 0;
    int cnt;

    assign readAddr = {ra1, ra0};

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk      (clk),
        .rst      (rst),
        .writeEn  (writeEn),
        .writeAddr(writeAddr),
        .writeData(writeData),
        .readAddr (readAddr),
        .readData (readData),
        .readBusy (readBusy),
        .issueEn  (issueEn),
        .issueAddr(issueAddr),
        .clearReq (clearReq),
        .clearBusy(clearBusy)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic        ien;
        logic [4:0]  iaddr;
        logic [4:0]  r0, r1;
        logic [63:0] d0, d1;
        logic        b0, b1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        writeEn = 1'b1; writeAddr = a; writeData = d;
        @(posedge clk); #1;
        writeEn = 1'b0;
    endtask

    task automatic iss(input logic [4:0] a);
        @(negedge clk);
        issueEn = 1'b1; issueAddr = a;
        @(posedge clk); #1;
        issueEn = 1'b0;
    endtask

    task automatic start_clear();
        @(negedge clk);
        clearReq = 1'b1;
        @(posedge clk); #1;
        clearReq = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd0,  64'hDEAD_BEEF, 1'b0, 5'd0,  5'd0,  5'd1, 64'h0,    ONES,     1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'd0,  64'h0,         1'b1, 5'd0,  5'd0,  5'd5, 64'h0,    ONES,     1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'd0,  64'h0,         1'b1, 5'd5,  5'd5,  5'd0, ONES,     64'h0,    1'b1, 1'b0};
        vecs[3] = '{1'b1, 5'd5,  64'h1234,      1'b0, 5'd0,  5'd5,  5'd7, 64'h1234, ONES,     1'b0, 1'b0};
        vecs[4] = '{1'b1, 5'd7,  64'h77,        1'b1, 5'd7,  5'd7,  5'd5, 64'h77,   64'h1234, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 5'd7,  64'h88,        1'b0, 5'd0,  5'd7,  5'd7, 64'h88,   64'h88,   1'b0, 1'b0};
        vecs[6] = '{1'b1, 5'd2,  64'h22,        1'b1, 5'd31, 5'd31, 5'd2, ONES,     64'h22,   1'b1, 1'b0};
        vecs[7] = '{1'b1, 5'd31, 64'h5,         1'b0, 5'd0,  5'd31, 5'd2, 64'h5,    64'h22,   1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_clearBusy", 64'(clearBusy), 64'h0);
        for (int i = 0; i < 32; i++) begin
            ra0 = 5'(i); ra1 = 5'(31 - i); #1;
            chk($sformatf("rst_d0_x%0d", i), readData[63:0], 64'h0);
            chk($sformatf("rst_d1_x%0d", 31 - i), readData[127:64], 64'h0);
            chk($sformatf("rst_b_x%0d", i), 64'(readBusy), 64'h0);
        end
        @(negedge clk); rst = 1'b1;

        // Fill with all ones, read back on both ports
        for (int i = 1; i < 32; i++) wr(5'(i), ONES);
        for (int i = 1; i < 32; i++) begin
            ra0 = 5'(i); ra1 = 5'(i - 1); #1;
            chk($sformatf("fill_d0_x%0d", i), readData[63:0], ONES);
            chk($sformatf("fill_d1_x%0d", i - 1), readData[127:64], (i == 1) ? 64'h0 : ONES);
        end

        // Vector table: apply one edge of write/issue, then read back
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            writeEn = vecs[v].wen; writeAddr = vecs[v].waddr; writeData = vecs[v].wdata;
            issueEn = vecs[v].ien; issueAddr = vecs[v].iaddr;
            @(posedge clk); #1;
            writeEn = 1'b0; issueEn = 1'b0;
            ra0 = vecs[v].r0; ra1 = vecs[v].r1; #1;
            chk($sformatf("vec%0d_d0", v), readData[63:0], vecs[v].d0);
            chk($sformatf("vec%0d_d1", v), readData[127:64], vecs[v].d1);
            chk($sformatf("vec%0d_b0", v), 64'(readBusy[0]), 64'(vecs[v].b0));
            chk($sformatf("vec%0d_b1", v), 64'(readBusy[1]), 64'(vecs[v].b1));
        end

        // Writeback visibility within the write cycle
        iss(5'd5);
        @(negedge clk);
        ra0 = 5'd5; writeEn = 1'b1; writeAddr = 5'd5; writeData = 64'hABCD; #1;
`ifdef REGFILE_BYPASS_EN
        chk("wcyc_data", readData[63:0], 64'hABCD);
        chk("wcyc_busy", 64'(readBusy[0]), 64'h0);
`else
        chk("wcyc_data", readData[63:0], 64'h1234);
        chk("wcyc_busy", 64'(readBusy[0]), 64'h1);
`endif
        @(posedge clk); #1;
        writeEn = 1'b0; #1;
        chk("wpost_data", readData[63:0], 64'hABCD);
        chk("wpost_busy", 64'(readBusy[0]), 64'h0);

        // Bulk clear: duration, ignored write/issue/re-request, final contents
        for (int i = 1; i < 32; i++) wr(5'(i), 64'hA5);
        iss(5'd9);
        ra0 = 5'd9; #1;
        chk("pend_x9", 64'(readBusy[0]), 64'h1);
        chk("pre_clear_busy", 64'(clearBusy), 64'h0);
        start_clear();
        cnt = 0;
        while (clearBusy && cnt < 100) begin
            cnt++;
            if (cnt == 11) begin
                ra0 = 5'd10; ra1 = 5'd11; #1;
                chk("mid_x10", readData[63:0], 64'h0);
                chk("mid_x11", readData[127:64], 64'hA5);
            end
            if (cnt == 20) begin
                writeEn = 1'b1; writeAddr = 5'd3; writeData = ONES;
                issueEn = 1'b1; issueAddr = 5'd4; clearReq = 1'b1;
            end
            @(posedge clk); #1;
            writeEn = 1'b0; issueEn = 1'b0; clearReq = 1'b0;
        end
        chk("clear_cycles", 64'(cnt), 64'd31);
        for (int i = 0; i < 32; i++) begin
            ra0 = 5'(i); ra1 = 5'(i); #1;
            chk($sformatf("clr_d_x%0d", i), readData[63:0], 64'h0);
            chk($sformatf("clr_b_x%0d", i), 64'(readBusy), 64'h0);
        end

        // Reset in the middle of a clear, then a fresh clear from x1
        for (int i = 1; i < 32; i++) wr(5'(i), 64'(i));
        iss(5'd9);
        start_clear();
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        ra0 = 5'd20; ra1 = 5'd9;
        rst = 1'b0; #1;
        chk("mrst_clearBusy", 64'(clearBusy), 64'h0);
        chk("mrst_x20", readData[63:0], 64'h0);
        chk("mrst_busy9", 64'(readBusy[1]), 64'h0);
        #1 rst = 1'b1;
        wr(5'd1, 64'h11);
        wr(5'd2, 64'h22);
        start_clear();
        chk("restart_busy", 64'(clearBusy), 64'h1);
        ra0 = 5'd1; ra1 = 5'd2;
        @(posedge clk); #1;
        chk("restart_x1", readData[63:0], 64'h0);
        chk("restart_x2_kept", readData[127:64], 64'h22);
        @(posedge clk); #1;
        chk("restart_x2", readData[127:64], 64'h0);
        cnt = 0;
        while (clearBusy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("restart_done", 64'(clearBusy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
